// File: rtl/uart_tx_pkg.sv
// Shared UART TX types and line-level constants.
// No logic, no latency, no backpressure.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a data word, even or odd by par_typ.
// Latency 0 (pure combinational); no backpressure.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    // Odd parity inverts the XOR so the total count of ones becomes odd.
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART frame serializer: start, LSB-first data, optional parity, stop (two with UART_TX_TWO_STOP_BITS_EN).
// Latency: start bit on the edge that accepts DATA_VALID; TX_OUT/BUSY registered.
// Backpressure: DATA_VALID is sampled only in IDLE; BUSY drops for >=1 cycle between frames.
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  TX_CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic                  tx_nxt, busy_nxt;
    logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] data_reg, data_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_bit_q, par_bit_nxt;
    logic                  par_calc;
`ifdef UART_TX_TWO_STOP_BITS_EN
    logic                  stop_cnt, stop_cnt_nxt;
`endif

    uart_parity_calc #(
        .WIDTH   (DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    always_ff @(posedge TX_CLK) begin
        if (!RST) begin
            state     <= IDLE;
            TX_OUT    <= IDLE_LEVEL;
            BUSY      <= 1'b0;
            bit_cnt   <= '0;
            data_reg  <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
            stop_cnt  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            TX_OUT    <= tx_nxt;
            BUSY      <= busy_nxt;
            bit_cnt   <= cnt_nxt;
            data_reg  <= data_nxt;
            par_en_q  <= par_en_nxt;
            par_bit_q <= par_bit_nxt;
`ifdef UART_TX_TWO_STOP_BITS_EN
            stop_cnt  <= stop_cnt_nxt;
`endif
        end
    end

    // data_reg shifts right as bits go out, so bit 0 is always the next data bit.
    always_comb begin
        state_nxt   = state;
        tx_nxt      = TX_OUT;
        busy_nxt    = BUSY;
        cnt_nxt     = bit_cnt;
        data_nxt    = data_reg;
        par_en_nxt  = par_en_q;
        par_bit_nxt = par_bit_q;
`ifdef UART_TX_TWO_STOP_BITS_EN
        stop_cnt_nxt = stop_cnt;
`endif
        case (state)
            IDLE: begin
                tx_nxt   = IDLE_LEVEL;
                busy_nxt = 1'b0;
                if (DATA_VALID) begin
                    data_nxt    = P_DATA;
                    par_en_nxt  = PAR_EN;
                    par_bit_nxt = par_calc;
                    cnt_nxt     = '0;
                    state_nxt   = START;
                    tx_nxt      = START_BIT;
                    busy_nxt    = 1'b1;
                end
            end
            START: begin
                tx_nxt    = data_reg[0];
                data_nxt  = data_reg >> 1;
                state_nxt = DATA;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_TWO_STOP_BITS_EN
                    stop_cnt_nxt = 1'b0;
`endif
                    if (par_en_q) begin
                        tx_nxt    = par_bit_q;
                        state_nxt = PARITY;
                    end else begin
                        tx_nxt    = STOP_BIT;
                        state_nxt = STOP;
                    end
                end else begin
                    tx_nxt   = data_reg[0];
                    data_nxt = data_reg >> 1;
                    cnt_nxt  = bit_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                tx_nxt    = STOP_BIT;
                state_nxt = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_BITS_EN
                if (!stop_cnt) begin
                    stop_cnt_nxt = 1'b1;
                    tx_nxt       = STOP_BIT;
                end else begin
                    tx_nxt    = IDLE_LEVEL;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
`else
                tx_nxt    = IDLE_LEVEL;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
`endif
            end
            default: begin
                tx_nxt    = IDLE_LEVEL;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
